// File: rtl/iter_alu.sv
// Registered EX-stage ALU: single-cycle integer ops with one-cycle latency, plus
// iterative multiply/divide into HI/LO with a valid/ready stall handshake.
//
// state | meaning
// IDLE  | ready for a request; single-cycle ops complete here
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | apply signs, write hi/lo, pulse out_valid
module iter_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             kill,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             dbz,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
   state_t state, state_nxt;

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   opnd, a_save;
   logic [SHW-1:0]     cnt;
   logic               neg_q, neg_r, md_div, div_zero;

   logic             accept, is_md, is_div, sgn;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum, diff, alu_res, a_mag, b_mag;
   logic             alu_ovf;

   assign accept = in_valid & in_ready;
   assign is_md  = (op >= 5'd16) && (op <= 5'd19);
   assign is_div = (op == 5'd18) || (op == 5'd19);
   assign sgn    = (op == 5'd16) || (op == 5'd18);
   assign shamt  = b[SHW-1:0];
   assign sum    = a + b;
   assign diff   = a - b;
   assign a_mag  = (sgn && a[WIDTH-1]) ? -a : a;
   assign b_mag  = (sgn && b[WIDTH-1]) ? -b : b;

   always_comb begin
      alu_res = a;
      alu_ovf = 1'b0;
      case (op)
         5'd0: alu_res = sum;
         5'd1: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         5'd2: alu_res = diff;
         5'd3: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         5'd4:  alu_res = a & b;
         5'd5:  alu_res = a | b;
         5'd6:  alu_res = ~(a | b);
         5'd7:  alu_res = a ^ b;
         5'd8:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         5'd9:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         5'd10: alu_res = a << shamt;
         5'd11: alu_res = a >> shamt;
         5'd12: alu_res = $signed(a) >>> shamt;
         default: alu_res = a;
      endcase
   end

   // Iteration datapath: prod holds {partial product, multiplier} or {remainder, dividend/quotient}
   logic [WIDTH:0]     mul_sum, div_shift, div_trial;
   logic               div_ge;
   logic [2*WIDTH-1:0] mul_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
   assign div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, opnd};
   assign div_ge    = ~div_trial[WIDTH];
   assign mul_fix   = neg_q ? -prod : prod;

   always_comb begin
      fix_hi = mul_fix[2*WIDTH-1:WIDTH];
      fix_lo = mul_fix[WIDTH-1:0];
      if (md_div) begin
         if (div_zero) begin
            fix_hi = a_save;
            fix_lo = '1;
         end else begin
            fix_hi = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
            fix_lo = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept && is_md) state_nxt = is_div ? S_DIV : S_MUL;
         S_MUL, S_DIV: begin
            if (kill)                           state_nxt = S_IDLE;
            else if (cnt == SHW'(WIDTH - 1))    state_nxt = S_FIX;
         end
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != S_IDLE);
      in_ready = (state == S_IDLE) & rst;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
         dbz       <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         prod      <= '0;
         opnd      <= '0;
         a_save    <= '0;
         cnt       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         md_div    <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (is_md) begin
                     prod     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                     opnd     <= is_div ? b_mag : a_mag;
                     a_save   <= a;
                     cnt      <= '0;
                     neg_q    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_r    <= sgn & a[WIDTH-1];
                     md_div   <= is_div;
                     div_zero <= is_div & (b == '0);
                  end else begin
                     out_valid <= 1'b1;
                     result    <= alu_res;
                     zero      <= (alu_res == '0);
                     ovf       <= alu_ovf;
                     dbz       <= 1'b0;
                     if (op == 5'd20) hi <= a;
                     if (op == 5'd21) lo <= a;
                  end
               end
            end
            S_MUL: begin
               if (!kill) begin
                  prod <= {mul_sum, prod[WIDTH-1:1]};
                  cnt  <= cnt + SHW'(1);
               end
            end
            S_DIV: begin
               if (!kill) begin
                  prod <= {(div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                           prod[WIDTH-2:0], div_ge};
                  cnt  <= cnt + SHW'(1);
               end
            end
            S_FIX: begin
               if (!kill) begin
                  hi        <= fix_hi;
                  lo        <= fix_lo;
                  out_valid <= 1'b1;
                  result    <= fix_lo;
                  zero      <= (fix_lo == '0);
                  ovf       <= 1'b0;
                  dbz       <= div_zero;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed corner cases then random ops checked
// against an arithmetic reference model using 64-bit integer math.
module tb_iter_alu;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         kill = 1'b0;
   logic [4:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         in_ready, out_valid, zero, ovf, dbz, busy;
   logic [W-1:0] result, hi, lo;

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_hi = '0;
   logic [W-1:0] exp_lo = '0;

   always #5 clk = ~clk;

   iter_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .kill(kill), .out_valid(out_valid), .result(result),
      .zero(zero), .ovf(ovf), .dbz(dbz), .busy(busy), .hi(hi), .lo(lo)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs == exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void sc_model(input logic [4:0] o, input logic [W-1:0] x, y,
                                    output logic [W-1:0] r, output logic v);
      longint sx, sy, t;
      logic [W-1:0] tr;
      int sh;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sh = int'(y[4:0]);
      v = 1'b0;
      r = x;
      case (o)
         5'd0: r = x + y;
         5'd1: begin t = sx + sy; tr = t[W-1:0]; r = tr; v = (t != longint'($signed(tr))); end
         5'd2: r = x - y;
         5'd3: begin t = sx - sy; tr = t[W-1:0]; r = tr; v = (t != longint'($signed(tr))); end
         5'd4: r = x & y;
         5'd5: r = x | y;
         5'd6: r = ~(x | y);
         5'd7: r = x ^ y;
         5'd8: r = (sx < sy) ? 32'd1 : 32'd0;
         5'd9: r = (x < y) ? 32'd1 : 32'd0;
         5'd10: r = x << sh;
         5'd11: r = x >> sh;
         5'd12: begin t = sx >>> sh; r = t[W-1:0]; end
         default: r = x;
      endcase
   endfunction

   function automatic void md_model(input logic [4:0] o, input logic [W-1:0] x, y,
                                    output logic [W-1:0] eh, el, output logic ed);
      longint sx, sy, p, q, rm;
      logic [63:0] up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ed = 1'b0;
      eh = '0;
      el = '0;
      case (o)
         5'd16: begin p = sx * sy; {eh, el} = p; end
         5'd17: begin up = {32'b0, x} * {32'b0, y}; {eh, el} = up; end
         default: begin
            if (y == '0) begin
               el = '1; eh = x; ed = 1'b1;
            end else if (o == 5'd18) begin
               q = sx / sy; rm = sx % sy;
               el = q[W-1:0]; eh = rm[W-1:0];
            end else begin
               el = x / y; eh = x % y;
            end
         end
      endcase
   endfunction

   // Called just after a falling edge; returns at the falling edge after acceptance.
   task automatic sc_step(input logic [4:0] o, input logic [W-1:0] x, y);
      logic [W-1:0] er;
      logic ev;
      sc_model(o, x, y, er, ev);
      chk1($sformatf("op%0d ready", o), in_ready, 1'b1);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (o == 5'd20) exp_hi = x;
      if (o == 5'd21) exp_lo = x;
      chk1($sformatf("op%0d out_valid", o), out_valid, 1'b1);
      chk($sformatf("op%0d result", o), result, er);
      chk1($sformatf("op%0d zero", o), zero, er == '0);
      chk1($sformatf("op%0d ovf", o), ovf, ev);
      chk1($sformatf("op%0d dbz", o), dbz, 1'b0);
      chk($sformatf("op%0d hi", o), hi, exp_hi);
      chk($sformatf("op%0d lo", o), lo, exp_lo);
   endtask

   task automatic md_op(input logic [4:0] o, input logic [W-1:0] x, y);
      logic [W-1:0] eh, el;
      logic ed;
      int cyc;
      logic hold_ok;
      cyc = 0;
      hold_ok = 1'b1;
      md_model(o, x, y, eh, el, ed);
      chk1($sformatf("op%0d ready", o), in_ready, 1'b1);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && cyc < 3 * W) begin
         if (in_ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chki($sformatf("op%0d latency", o), cyc, W + 1);
      chk1($sformatf("op%0d stall", o), hold_ok, 1'b1);
      exp_hi = eh;
      exp_lo = el;
      chk($sformatf("op%0d hi a=%h b=%h", o, x, y), hi, eh);
      chk($sformatf("op%0d lo a=%h b=%h", o, x, y), lo, el);
      chk($sformatf("op%0d result", o), result, el);
      chk1($sformatf("op%0d zero", o), zero, el == '0);
      chk1($sformatf("op%0d dbz", o), dbz, ed);
      chk1($sformatf("op%0d ovf", o), ovf, 1'b0);
      chk1($sformatf("op%0d ready after", o), in_ready, 1'b1);
   endtask

   task automatic run_op(input logic [4:0] o, input logic [W-1:0] x, y);
      if (o >= 5'd16 && o <= 5'd19) md_op(o, x, y);
      else sc_step(o, x, y);
   endtask

   function automatic logic [W-1:0] rand_val();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 16));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      logic never_valid;

      // reset held with a pending request
      in_valid = 1'b1; op = 5'd1; a = 32'd1; b = 32'd2;
      repeat (3) @(negedge clk);
      chk1("rst out_valid", out_valid, 1'b0);
      chk("rst hi", hi, '0);
      chk("rst lo", lo, '0);
      chk1("rst in_ready", in_ready, 1'b0);
      chk1("rst busy", busy, 1'b0);
      rst = 1'b1;
      in_valid = 1'b0;
      #1 chk1("release in_ready", in_ready, 1'b1);

      // back-to-back single-cycle ops
      sc_step(5'd1, 32'h7FFF_FFFF, 32'd1);
      sc_step(5'd3, 32'd5, 32'd5);
      sc_step(5'd12, 32'h8000_0000, 32'd4);
      sc_step(5'd8, 32'hFFFF_FFFF, 32'd1);
      sc_step(5'd9, 32'hFFFF_FFFF, 32'd1);
      sc_step(5'd10, 32'h0000_0F0F, 32'h0000_0024);
      sc_step(5'd25, 32'hDEAD_BEEF, 32'd7);

      // kill while idle does not block acceptance
      kill = 1'b1;
      sc_step(5'd0, 32'd3, 32'd4);
      kill = 1'b0;

      md_op(5'd16, 32'hFFFF_FFFD, 32'd7);
      md_op(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      md_op(5'd18, 32'hFFFF_FFF9, 32'd2);
      md_op(5'd19, 32'd9, 32'd0);
      md_op(5'd18, 32'h8000_0000, 32'hFFFF_FFFF);
      md_op(5'd18, 32'hFFFF_FFF0, 32'd0);

      // kill mid-divide leaves preloaded hi/lo intact
      sc_step(5'd20, 32'h1234, 32'd0);
      sc_step(5'd21, 32'h1234, 32'd0);
      op = 5'd18; a = 32'hFFFF_FF9C; b = 32'd3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk1("kill out_valid", out_valid, 1'b0);
      chk("kill hi", hi, 32'h1234);
      chk("kill lo", lo, 32'h1234);
      chk1("kill in_ready", in_ready, 1'b1);
      chk1("kill busy", busy, 1'b0);
      never_valid = 1'b1;
      repeat (W + 2) begin
         @(negedge clk);
         if (out_valid !== 1'b0) never_valid = 1'b0;
      end
      chk1("kill no late out_valid", never_valid, 1'b1);

      // async reset mid-multiply
      op = 5'd16; a = 32'd123; b = 32'hFFFF_FFD3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("areset hi", hi, '0);
      chk("areset lo", lo, '0);
      chk1("areset busy", busy, 1'b0);
      chk1("areset out_valid", out_valid, 1'b0);
      chk1("areset in_ready", in_ready, 1'b0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      rst = 1'b1;
      #1 chk1("areset release ready", in_ready, 1'b1);
      @(negedge clk);

      // random mix, then random multiply/divide
      for (int i = 0; i < 80; i++)
         run_op(5'($urandom_range(0, 31)), rand_val(), rand_val());
      for (int i = 0; i < 16; i++)
         run_op(5'($urandom_range(16, 19)), rand_val(), rand_val());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
